fifo_push_arbiter: RTL
======================

# fifo_push_arbiter

Round-robin arbiter that shares the push side of one FIFO between `NUM_REQ` requesters. It sits directly in front of the FIFO. Each requester presents a valid/grant handshake identical to the FIFO push port. The arbiter locks one requester for a burst of up to `MAX_BURST` beats before rotating, so beats from different sources are never interleaved inside a burst.

## Interface
- `NUM_REQ`, 4, number of requesters; must be ≥2, need not be a power of two
- `DATA_WIDTH`, 32, payload width parameter; data buses are `DATA_WIDTH+1` bits (`[DATA_WIDTH:0]`), matching the FIFO
- `MAX_BURST`, 4, maximum beats per ownership; must be ≥1

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid_i` in `NUM_REQ`: requester i has a beat
- `req_data_i` in `NUM_REQ` x (`DATA_WIDTH+1`): per-requester payload
- `req_grant_o` out `NUM_REQ`: beat of requester i is accepted this cycle
- `fifo_push_valid_o` out 1: to FIFO `push_valid_i`
- `fifo_push_data_o` out `DATA_WIDTH+1`: to FIFO `push_data_i`
- `fifo_push_grant_i` in 1: from FIFO `push_grant_o` (not full)
- `owner_o` out `$clog2(NUM_REQ)`: current or last owner index
- `busy_o` out 1: high in state OWN

## Operation
- Two states, `ARB_IDLE` and `ARB_OWN`. Registers: `state`, `owner`, `rr_ptr`, `beat_cnt` (`$clog2(MAX_BURST+1)` bits).
- **IDLE:**
  - Search `req_valid_i` starting at `rr_ptr`, upward, wrapping modulo `NUM_REQ`.
  - On the first hit: `owner <= hit`, `beat_cnt <= 0`, `state <= OWN`.
  - No hit: stay in IDLE.
  - No transfer occurs in IDLE.
- **OWN (combinational outputs):**
  - `fifo_push_valid_o = req_valid_i[owner]`
  - `fifo_push_data_o = req_data_i[owner]`
  - `req_grant_o[owner] = fifo_push_grant_i`; all other grants are 0.
  - A grant does not depend on the requester's own valid.
- **Beat:** `fifo_push_valid_o && fifo_push_grant_i`. Each beat increments `beat_cnt`.
- **Release conditions** (either one ends the burst):
  - A beat occurs with `beat_cnt == MAX_BURST-1`. That beat still transfers.
  - `req_valid_i[owner] == 0` in an OWN cycle. No transfer that cycle.
- **On release:** `state <= IDLE` and `rr_ptr <= (owner+1) mod NUM_REQ`.
- **Outputs outside OWN:** grants, `fifo_push_valid_o` and `fifo_push_data_o` are all 0 in IDLE.
- **FIFO full** (`fifo_push_grant_i = 0`): owner is held indefinitely, `beat_cnt` is frozen, and the requester's data must stay stable. There is no timeout.

## Timing
- **Reset values:**
  - `state = IDLE`, `owner = 0`, `rr_ptr = 0`, `beat_cnt = 0`
  - all outputs 0
  - Reset applies immediately on `rst` rise, independent of `clk`.
- **Arbitration latency:**
  - First beat no earlier than 1 cycle after valid is seen in IDLE.
  - Every burst ends with exactly one IDLE cycle before the next owner is granted.
- **Full-rate throughput:** `MAX_BURST` beats per `MAX_BURST+1` cycles when the FIFO never stalls.
- **Same-requester re-grant:** a sole active requester is re-granted after the one-cycle IDLE gap.
- **Reset mid-burst:** the burst is abandoned and any in-flight beat is not transferred. After reset, the search starts at requester 0.
- **`owner_o` timing:** `owner_o` updates the cycle after selection and holds through IDLE.

## Structure
- Package `fifo_arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e`
  - helper `localparam` widths `IDX_W` and `CNT_W`
- Sub-module `rr_picker` is purely combinational.
  - Inputs: `NUM_REQ` request vector and start pointer.
  - Outputs: `found` and index.
  - The top instantiates it once.

## Test plan
All scenarios use `NUM_REQ=4`, `MAX_BURST=4`, `DATA_WIDTH=32`.

1. **Reset:** `rst=1` with all `req_valid_i=4'hF` → grants 0, `fifo_push_valid_o=0`, `busy_o=0`, `owner_o=0`; the same holds while `rst` stays high.
2. **Single requester:** only req 2 valid, data 0x0_0000_0A00..0A03, FIFO grant 1 → IDLE at cycle 0, beats at cycles 1–4 carrying those 4 words in order, IDLE at cycle 5, req 2 re-owned at cycle 6.
3. **Round-robin order:** all four valid continuously → owners 0,1,2,3,0, each exactly 4 beats, one idle cycle between bursts; no cross-requester interleaving seen at the FIFO.
4. **FIFO stall:** FIFO grant low for 3 cycles after beat 2 of req 1 → `req_grant_o` all 0, `beat_cnt` stays 2, valid/data held; the burst resumes and completes with a total of 4 beats.
5. **Early release:** req 1 drops valid after 2 beats while req 3 is valid → IDLE the next cycle, then owner 3; req 1 gets no third beat.
6. **Async reset mid-burst:** `rst` pulsed between clock edges during beat 3 of owner 2 → outputs go to 0 before the next edge; with req 2 and req 3 valid after reset, owner 2 is picked first (search starts at 0).

Source files
------------

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and width helpers for the FIFO push-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  // Width of a requester index; a single-bit index is kept even for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter able to hold 0..b.
  function automatic int cnt_width(input int b);
    return $clog2(b + 1);
  endfunction

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int IDX_W         = idx_width(NUM_REQ_DEF);
  localparam int CNT_W         = cnt_width(MAX_BURST_DEF);

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester and FIFO push-side signals of the arbiter, grouped as one bundle.
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  import fifo_arb_pkg::*;

  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0][DATA_WIDTH:0] req_data_i;
  logic [NUM_REQ-1:0]               req_grant_o;
  logic                             fifo_push_valid_o;
  logic [DATA_WIDTH:0]              fifo_push_data_o;
  logic                             fifo_push_grant_i;
  logic [IW-1:0]                    owner_o;
  logic                             busy_o;

  // Arbiter side.
  modport master (
    input  req_valid_i, req_data_i, fifo_push_grant_i,
    output req_grant_o, fifo_push_valid_o, fifo_push_data_o, owner_o, busy_o
  );

  // Requesters / FIFO side.
  modport slave (
    output req_valid_i, req_data_i, fifo_push_grant_i,
    input  req_grant_o, fifo_push_valid_o, fifo_push_data_o, owner_o, busy_o
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after start_i, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [idx_width(NUM_REQ)-1:0]   start_i,
  output logic                            found_o,
  output logic [idx_width(NUM_REQ)-1:0]   idx_o
);

  localparam int IW = idx_width(NUM_REQ);

  // Walk NUM_REQ positions from the start pointer, keeping the first hit.
  always_comb begin
    int unsigned cand;
    logic        hit;
    hit     = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
      cand = int'(start_i) + k;
      if (cand >= unsigned'(NUM_REQ)) begin
        cand = cand - unsigned'(NUM_REQ);
      end
      if (!hit && req_i[IW'(cand)]) begin
        hit   = 1'b1;
        idx_o = IW'(cand);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port; an owner is locked for up to
// MAX_BURST beats, and every burst is followed by a single IDLE cycle.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_push_arbiter_if.master bus
);

  localparam int              IW        = idx_width(NUM_REQ);
  localparam int              CW        = cnt_width(MAX_BURST);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;

  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                owner_valid;
  logic [NUM_REQ-1:0]  grant;
  logic                push_valid;
  logic [DATA_WIDTH:0] push_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (bus.req_valid_i),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state, burst accounting and push-port muxing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    grant       = '0;
    push_valid  = 1'b0;
    push_data   = '0;
    owner_valid = bus.req_valid_i[owner_q];
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_OWN;
        end
      end
      ARB_OWN: begin
        push_valid     = owner_valid;
        push_data      = bus.req_data_i[owner_q];
        grant[owner_q] = bus.fifo_push_grant_i;
        // A dropped valid and the final beat both end the burst the same way.
        if (!owner_valid || (bus.fifo_push_grant_i && (beat_cnt_q == LAST_BEAT))) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end else if (bus.fifo_push_grant_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.req_grant_o       = grant;
  assign bus.fifo_push_valid_o = push_valid;
  assign bus.fifo_push_data_o  = push_data;
  assign bus.owner_o           = owner_q;
  assign bus.busy_o            = (state_q == ARB_OWN);

endmodule
